// File: rtl/rpll_dyn_cfg_ctrl.sv
// rPLL dynamic-divider sequencer: PLL reset pulsing, lock timeout/retry, lock debounce, core reset.
// Optional macro LOCK_LOSS_RECOVER_EN: lock loss in LOCKED re-issues the PLL reset pulse.
module rpll_dyn_cfg_ctrl #(
  parameter int          RST_HOLD     = 16,
  parameter int          LOCK_TIMEOUT = 65536,
  parameter int          LOCK_STABLE  = 1024,
  parameter int          MAX_RETRY    = 3,
  parameter logic [5:0]  DEF_IDSEL    = 6'd0,
  parameter logic [5:0]  DEF_FBDSEL   = 6'd0,
  parameter logic [5:0]  DEF_ODSEL    = 6'd0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [5:0]                     cfg_idsel,
  input  logic [5:0]                     cfg_fbdsel,
  input  logic [5:0]                     cfg_odsel,
  input  logic                           pll_lock,
  output logic                           pll_reset,
  output logic [5:0]                     pll_idsel,
  output logic [5:0]                     pll_fbdsel,
  output logic [5:0]                     pll_odsel,
  output logic                           locked,
  output logic                           sys_rst,
  output logic                           busy,
  output logic                           err,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int HD_W = $clog2(RST_HOLD + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W = $clog2(LOCK_STABLE + 1);
  localparam int RC_W = $clog2(MAX_RETRY + 1);

  localparam logic [HD_W-1:0] HD_LAST = HD_W'(RST_HOLD - 1);
  localparam logic [HD_W-1:0] HD_MAX  = HD_W'(RST_HOLD);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(LOCK_TIMEOUT);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(LOCK_STABLE);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t            state_reg, state_next;
  logic [HD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [ST_W-1:0]   st_cnt_reg, st_cnt_next;
  logic [RC_W-1:0]   retry_reg, retry_next, retry_inc;
  logic              err_reg, err_next;
  logic [5:0]        idsel_reg, idsel_next;
  logic [5:0]        fbdsel_reg, fbdsel_next;
  logic [5:0]        odsel_reg, odsel_next;
  logic              pll_reset_reg, locked_reg, sys_rst_reg, busy_reg, cfg_ready_reg;
  logic [1:0]        sync_reg;
  logic [1:0]        sync_in;
  logic              lock_sync;
  logic              accept;

  // Two-stage synchroniser for the asynchronous PLL lock.
  assign sync_in = {sync_reg[0], pll_lock};
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b0;
        else     sync_reg[gi] <= sync_in[gi];
      end
    end
  endgenerate
  assign lock_sync = sync_reg[1];

  assign accept    = cfg_valid & cfg_ready_reg;
  assign retry_inc = (retry_reg != RC_MAX) ? retry_reg + 1'b1 : retry_reg;

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    st_cnt_next   = st_cnt_reg;
    retry_next    = retry_reg;
    err_next      = err_reg;
    idsel_next    = idsel_reg;
    fbdsel_next   = fbdsel_reg;
    odsel_next    = odsel_reg;
    if (accept) begin
      idsel_next    = cfg_idsel;
      fbdsel_next   = cfg_fbdsel;
      odsel_next    = cfg_odsel;
      retry_next    = '0;
      err_next      = 1'b0;
      hold_cnt_next = '0;
      st_cnt_next   = '0;
      state_next    = S_RST_HOLD;
    end else begin
      case (state_reg)
        S_RST_HOLD: begin
          if (hold_cnt_reg >= HD_LAST) begin
            state_next  = S_WAIT_LOCK;
            to_cnt_next = '0;
          end else if (hold_cnt_reg != HD_MAX) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (to_cnt_reg != TO_MAX) to_cnt_next = to_cnt_reg + 1'b1;
          // The sample that leaves WAIT_LOCK counts as the first stable one.
          if (lock_sync) begin
            st_cnt_next = ST_W'(1);
            state_next  = (LOCK_STABLE <= 1) ? S_LOCKED : S_STABLE;
          end else if (to_cnt_reg >= TO_LAST) begin
            retry_next = retry_inc;
            if (retry_inc < RC_MAX) begin
              state_next    = S_RST_HOLD;
              hold_cnt_next = '0;
            end else begin
              state_next = S_FAIL;
              err_next   = 1'b1;
            end
          end
        end
        S_STABLE: begin
          if (lock_sync) begin
            if (st_cnt_reg != ST_MAX) st_cnt_next = st_cnt_reg + 1'b1;
            if (st_cnt_reg >= ST_LAST) state_next = S_LOCKED;
          end else begin
            st_cnt_next = '0;
            state_next  = S_WAIT_LOCK;
          end
        end
        S_LOCKED: begin
          if (!lock_sync) begin
`ifdef LOCK_LOSS_RECOVER_EN
            state_next    = S_RST_HOLD;
            hold_cnt_next = '0;
            retry_next    = '0;
`else
            state_next  = S_WAIT_LOCK;
            to_cnt_next = '0;
`endif
          end
        end
        S_FAIL: begin
          state_next = S_FAIL;
        end
        default: begin
          state_next    = S_RST_HOLD;
          hold_cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RST_HOLD;
      hold_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      st_cnt_reg    <= '0;
      retry_reg     <= '0;
      err_reg       <= 1'b0;
      idsel_reg     <= DEF_IDSEL;
      fbdsel_reg    <= DEF_FBDSEL;
      odsel_reg     <= DEF_ODSEL;
      pll_reset_reg <= 1'b1;
      locked_reg    <= 1'b0;
      sys_rst_reg   <= 1'b1;
      busy_reg      <= 1'b1;
      cfg_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      st_cnt_reg    <= st_cnt_next;
      retry_reg     <= retry_next;
      err_reg       <= err_next;
      idsel_reg     <= idsel_next;
      fbdsel_reg    <= fbdsel_next;
      odsel_reg     <= odsel_next;
      pll_reset_reg <= (state_next == S_RST_HOLD) || (state_next == S_FAIL);
      locked_reg    <= (state_next == S_LOCKED);
      sys_rst_reg   <= (state_next != S_LOCKED);
      busy_reg      <= (state_next == S_RST_HOLD) || (state_next == S_WAIT_LOCK) ||
                       (state_next == S_STABLE);
      cfg_ready_reg <= (state_next == S_LOCKED) || (state_next == S_FAIL);
    end
  end

  assign pll_reset  = pll_reset_reg;
  assign pll_idsel  = idsel_reg;
  assign pll_fbdsel = fbdsel_reg;
  assign pll_odsel  = odsel_reg;
  assign locked     = locked_reg;
  assign sys_rst    = sys_rst_reg;
  assign busy       = busy_reg;
  assign err        = err_reg;
  assign cfg_ready  = cfg_ready_reg;
  assign retry_cnt  = retry_reg;

endmodule

// File: tb/tb_rpll_dyn_cfg_ctrl.sv
// Bench for rpll_dyn_cfg_ctrl: cycle model of the sequencing rules, directed scenarios, random stimulus.
module tb_rpll_dyn_cfg_ctrl;

  localparam int RST_HOLD     = 4;
  localparam int LOCK_TIMEOUT = 32;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 2;
  localparam logic [5:0] DEF_ID = 6'h0A;
  localparam logic [5:0] DEF_FB = 6'h15;
  localparam logic [5:0] DEF_OD = 6'h03;
`ifdef LOCK_LOSS_RECOVER_EN
  localparam int RECOVER = 1;
`else
  localparam int RECOVER = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, locked, sys_rst, busy, err;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [1:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rpll_dyn_cfg_ctrl #(
    .RST_HOLD(RST_HOLD), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
    .MAX_RETRY(MAX_RETRY), .DEF_IDSEL(DEF_ID), .DEF_FBDSEL(DEF_FB), .DEF_ODSEL(DEF_OD)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
    .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .locked(locked),
    .sys_rst(sys_rst), .busy(busy), .err(err), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus "how long have we been here" counts.
  localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_LOCK = 3, P_FAIL = 4;
  bit         m_valid = 0;
  int         m_phase, m_hold, m_wait, m_stab, m_retry;
  bit         m_err, m_s1, m_s2, m_synced;
  logic [5:0] m_id, m_fb, m_od;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_phase = P_HOLD; m_hold = 0; m_wait = 0; m_stab = 0; m_retry = 0;
      m_err = 0; m_s1 = 0; m_s2 = 0;
      m_id = DEF_ID; m_fb = DEF_FB; m_od = DEF_OD;
    end else if (m_valid) begin
      m_synced = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
      if (cfg_valid && (m_phase == P_LOCK || m_phase == P_FAIL)) begin
        m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel;
        m_retry = 0; m_err = 0; m_phase = P_HOLD; m_hold = 0;
      end else if (m_phase == P_HOLD) begin
        m_hold++;
        if (m_hold >= RST_HOLD) begin m_phase = P_WAIT; m_wait = 0; end
      end else if (m_phase == P_WAIT) begin
        m_wait++;
        if (m_synced) begin
          m_stab = 1;
          m_phase = (m_stab >= LOCK_STABLE) ? P_LOCK : P_STAB;
        end else if (m_wait >= LOCK_TIMEOUT) begin
          m_retry++;
          if (m_retry < MAX_RETRY) begin m_phase = P_HOLD; m_hold = 0; end
          else begin m_phase = P_FAIL; m_err = 1; end
        end
      end else if (m_phase == P_STAB) begin
        if (m_synced) begin
          m_stab++;
          if (m_stab >= LOCK_STABLE) m_phase = P_LOCK;
        end else begin
          m_stab = 0; m_phase = P_WAIT;
        end
      end else if (m_phase == P_LOCK && !m_synced) begin
        if (RECOVER != 0) begin m_phase = P_HOLD; m_hold = 0; m_retry = 0; end
        else begin m_phase = P_WAIT; m_wait = 0; end
      end
    end
  end

  function automatic logic [25:0] m_vec();
    logic lk;
    lk = (m_phase == P_LOCK);
    return {(m_phase == P_HOLD || m_phase == P_FAIL), m_id, m_fb, m_od, lk, !lk,
            (m_phase == P_HOLD || m_phase == P_WAIT || m_phase == P_STAB), m_err,
            (lk || m_phase == P_FAIL), 2'(m_retry)};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      logic [25:0] act, exp;
      act = {pll_reset, pll_idsel, pll_fbdsel, pll_odsel, locked, sys_rst, busy, err,
             cfg_ready, retry_cnt};
      exp = m_vec();
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle after the reset edge).
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int run;

  initial begin
    // 1 + 5: lock from cycle 10, then lose it while locked.
    @(negedge clk);
    do_reset();
    chk("rst_idsel", pll_idsel, DEF_ID);
    chk("rst_busy", busy, 1);
    chk("rst_ready", cfg_ready, 0);
    for (int c = 0; c <= 38; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10) pll_lock = 1'b1;
      if (c == 23) pll_lock = 1'b0;
      if (c == 28) pll_lock = 1'b1;
      if (c < 4)   chk("t1_reset_pulse", pll_reset, 1);
      if (c == 4)  chk("t1_reset_release", pll_reset, 0);
      if (c == 19) chk("t1_locked_early", locked, 0);
      if (c == 20) begin
        chk("t1_locked", locked, 1);
        chk("t1_sys_rst", sys_rst, 0);
        chk("t1_busy", busy, 0);
      end
      if (c == 25) chk("t5_locked_held", locked, 1);
      if (c == 26) begin
        chk("t5_sys_rst", sys_rst, 1);
        chk("t5_pulse", pll_reset, RECOVER);
      end
      if (c == 30) chk("t5_pulse_end", pll_reset, 0);
      if (c == 37) chk("t5_relock_early", locked, 0);
      if (c == 38) chk("t5_relock", locked, 1);
    end

    // 2 + 3: no lock -> FAIL, then a new configuration.
    pll_lock = 1'b0;
    do_reset();
    for (int c = 0; c <= 85; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 35) chk("t2_first_wait", pll_reset, 0);
      if (c == 36) begin
        chk("t2_retry1", retry_cnt, 1);
        chk("t2_pulse2", pll_reset, 1);
      end
      if (c == 40) chk("t2_pulse2_end", pll_reset, 0);
      if (c == 71) chk("t2_err_early", err, 0);
      if (c == 72) begin
        chk("t2_err", err, 1);
        chk("t2_fail_reset", pll_reset, 1);
        chk("t2_retry2", retry_cnt, 2);
        chk("t2_ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_idsel = 6'h12; cfg_fbdsel = 6'h34; cfg_odsel = 6'h05;
      end
      if (c == 73) begin
        cfg_valid = 1'b0;
        pll_lock  = 1'b1;
        chk("t3_idsel", pll_idsel, 6'h12);
        chk("t3_fbdsel", pll_fbdsel, 6'h34);
        chk("t3_odsel", pll_odsel, 6'h05);
        chk("t3_err_clr", err, 0);
        chk("t3_ready_drop", cfg_ready, 0);
      end
      if (c == 77) chk("t3_pulse_end", pll_reset, 0);
      if (c == 85) chk("t3_locked", locked, 1);
    end

    // 4: one-cycle glitch while counting stable samples.
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 7) pll_lock = 1'b0;
      if (c == 8) pll_lock = 1'b1;
      if (c == 17) chk("t4_locked_early", locked, 0);
      if (c == 18) chk("t4_locked", locked, 1);
    end

    // 6: reset in WAIT_LOCK with a configuration offered.
    pll_lock = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    cfg_valid = 1'b1; cfg_idsel = 6'h3F; cfg_fbdsel = 6'h2A; cfg_odsel = 6'h11;
    do_reset();
    chk("t6_busy", busy, 1);
    chk("t6_pll_reset", pll_reset, 1);
    repeat (3) @(negedge clk);
    chk("t6_def_id", pll_idsel, DEF_ID);
    chk("t6_def_od", pll_odsel, DEF_OD);
    cfg_valid = 1'b0;

    // Random phase: lock runs with glitches and long outages, offers and resets.
    run = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (run == 0) begin
        pll_lock = ~pll_lock;
        run = pll_lock ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 100));
      end else begin
        run--;
      end
      cfg_valid  = ($urandom_range(0, 9) == 0);
      cfg_idsel  = 6'($urandom_range(0, 63));
      cfg_fbdsel = 6'($urandom_range(0, 63));
      cfg_odsel  = 6'($urandom_range(0, 63));
      rst        = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
